// File: rtl/kbd_scanner.sv
// Keyboard matrix scanner: strobes one column at a time, debounces per scan
// frame and hands a 6-bit {col,row} key code to the core over valid/ack.
module kbd_scanner #(
  parameter int NUM_COLS = 5,
  parameter int NUM_ROWS = 8,
  parameter int SCAN_DIV = 520,
  parameter int DEBOUNCE = 4
) (
  input  logic                clk_in,
  input  logic                reset_in,
  input  logic [NUM_ROWS-1:0] rows_in,
  output logic [NUM_COLS-1:0] columns_o,
  output logic [5:0]          key_code_o,
  output logic                key_valid_o,
  input  logic                key_ack_in,
  output logic                key_down_o,
  output logic                overrun_o
);

  localparam int               DWELL_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [2:0]       COL_LAST   = 3'(NUM_COLS - 1);
  localparam logic [3:0]       DB_TARGET  = 4'(DEBOUNCE);

  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HELD} state_t;

  // scan datapath
  logic [NUM_ROWS-1:0] r_rows_meta;
  logic [NUM_ROWS-1:0] r_rows_sync;
  logic [DWELL_W-1:0]  r_dwell;
  logic [2:0]          r_col;
  logic                r_eval;
  logic                r_hit_any;
  logic                r_held_seen;
  logic [5:0]          r_hit_code;

  logic [7:0]          w_rows8;
  logic [2:0]          w_low_row;
  logic                w_sample;
  logic                w_frame_end;
  logic                w_held_here;

  // key FSM and handshake
  state_t              r_state;
  state_t              w_state_next;
  logic [3:0]          r_count;
  logic [3:0]          w_count_next;
  logic [3:0]          r_release;
  logic [3:0]          w_release_next;
  logic [5:0]          r_cand;
  logic [5:0]          w_cand_next;
  logic [5:0]          r_key_code;
  logic [5:0]          w_key_code_next;
  logic                r_valid;
  logic                w_valid_next;
  logic                r_down;
  logic                w_down_next;
  logic                r_overrun;
  logic                w_overrun_next;
  logic                w_accept;
  logic [5:0]          w_accept_code;
  logic [3:0]          w_count_inc;
  logic [3:0]          w_release_inc;

  for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
    assign columns_o[gi] = (r_col == 3'(gi));
  end

  assign w_rows8     = 8'(r_rows_sync);
  assign w_sample    = (r_dwell == DWELL_LAST);
  assign w_frame_end = w_sample && (r_col == COL_LAST);
  assign w_held_here = (r_col == r_key_code[5:3]) && w_rows8[r_key_code[2:0]];

  // Lowest active row wins within a column.
  always_comb begin
    w_low_row = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_rows8[i]) w_low_row = 3'(i);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_rows_meta <= '0;
      r_rows_sync <= '0;
      r_dwell     <= '0;
      r_col       <= 3'd0;
      r_eval      <= 1'b0;
      r_hit_any   <= 1'b0;
      r_hit_code  <= 6'd0;
      r_held_seen <= 1'b0;
    end else begin
      r_rows_meta <= rows_in;
      r_rows_sync <= r_rows_meta;
      r_eval      <= w_frame_end;
      if (w_sample) begin
        r_dwell <= '0;
        r_col   <= (r_col == COL_LAST) ? 3'd0 : r_col + 3'd1;
      end else begin
        r_dwell <= r_dwell + 1'b1;
      end
      // Frame summary is consumed during r_eval, then cleared for the next frame.
      if (r_eval) begin
        r_hit_any   <= 1'b0;
        r_hit_code  <= 6'd0;
        r_held_seen <= 1'b0;
      end else if (w_sample) begin
        if (!r_hit_any && (|r_rows_sync)) begin
          r_hit_any  <= 1'b1;
          r_hit_code <= {r_col, w_low_row};
        end
        if (w_held_here) r_held_seen <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_count_next    = r_count;
    w_release_next  = r_release;
    w_cand_next     = r_cand;
    w_key_code_next = r_key_code;
    w_valid_next    = r_valid;
    w_down_next     = r_down;
    w_overrun_next  = 1'b0;
    w_accept        = 1'b0;
    w_accept_code   = r_cand;
    w_count_inc     = r_count + 4'd1;
    w_release_inc   = r_release + 4'd1;

    if (r_eval) begin
      unique case (r_state)
        ST_SCAN: begin
          if (r_hit_any) begin
            w_cand_next   = r_hit_code;
            w_count_next  = 4'd1;
            w_accept_code = r_hit_code;
            if (DB_TARGET == 4'd1) w_accept = 1'b1;
            else                   w_state_next = ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (r_hit_any && (r_hit_code == r_cand)) begin
            w_count_next = w_count_inc;
            if (w_count_inc == DB_TARGET) w_accept = 1'b1;
          end else begin
            w_state_next = ST_SCAN;
            w_count_next = 4'd0;
          end
        end
        ST_HELD: begin
          // Only the held key matters here; other keys are not rolled over.
          if (r_held_seen) begin
            w_release_next = 4'd0;
          end else begin
            w_release_next = w_release_inc;
            if (w_release_inc == DB_TARGET) begin
              w_down_next  = 1'b0;
              w_state_next = ST_SCAN;
            end
          end
        end
        default: w_state_next = ST_SCAN;
      endcase
    end

    // A fresh accept always beats a coincident ack.
    if (w_accept) begin
      w_key_code_next = w_accept_code;
      w_valid_next    = 1'b1;
      w_down_next     = 1'b1;
      w_state_next    = ST_HELD;
      w_release_next  = 4'd0;
      w_overrun_next  = r_valid && !key_ack_in;
    end else if (r_valid && key_ack_in) begin
      w_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state    <= ST_SCAN;
      r_count    <= 4'd0;
      r_release  <= 4'd0;
      r_cand     <= 6'd0;
      r_key_code <= 6'd0;
      r_valid    <= 1'b0;
      r_down     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_count    <= w_count_next;
      r_release  <= w_release_next;
      r_cand     <= w_cand_next;
      r_key_code <= w_key_code_next;
      r_valid    <= w_valid_next;
      r_down     <= w_down_next;
      r_overrun  <= w_overrun_next;
    end
  end

  assign key_code_o  = r_key_code;
  assign key_valid_o = r_valid;
  assign key_down_o  = r_down;
  assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_kbd_scanner.sv
// Bench for kbd_scanner: a simulated key matrix driven from the column strobes,
// and a frame-level model of debounce/handshake checked every cycle.
module tb_kbd_scanner;

  localparam int NC    = 5;
  localparam int NR    = 8;
  localparam int SD    = 4;
  localparam int DB    = 2;
  localparam int FRAME = NC * SD;

  logic          clk = 1'b0;
  logic          rst;
  logic          ack;
  logic [NR-1:0] rows;
  logic [NC-1:0] cols;
  logic [5:0]    code;
  logic          valid;
  logic          down;
  logic          ovr;

  // mat: keys physically pressed now; plan: keys to press from the next frame start;
  // snap: what the frame currently being scanned sees.
  logic [NC-1:0][NR-1:0] mat;
  logic [NC-1:0][NR-1:0] plan;
  logic [NC-1:0][NR-1:0] snap;

  int   n;
  int   tests;
  int   fails;
  bit   checking;

  int         m_state;  // 0 idle, 1 confirming, 2 held
  int         m_cnt;
  int         m_rel;
  logic [5:0] m_cand;
  logic [5:0] e_code;
  logic       e_valid;
  logic       e_down;
  logic       e_ovr;

  kbd_scanner #(
    .NUM_COLS(NC), .NUM_ROWS(NR), .SCAN_DIV(SD), .DEBOUNCE(DB)
  ) dut (
    .clk_in     (clk),
    .reset_in   (rst),
    .rows_in    (rows),
    .columns_o  (cols),
    .key_code_o (code),
    .key_valid_o(valid),
    .key_ack_in (ack),
    .key_down_o (down),
    .overrun_o  (ovr)
  );

  always #5 clk = ~clk;

  // Passive keyboard: a pressed key shorts its driven column onto its row.
  always_comb begin
    rows = '0;
    for (int c = 0; c < NC; c++) begin
      if (cols[c]) rows = rows | mat[c];
    end
  end

  task automatic lit(input string name, input logic [7:0] got, input logic [7:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h (n=%0d)", name, got, want, n);
    end
  endtask

  // One clock: check outputs of this cycle, drive inputs, advance the model
  // to what must be visible after the coming edge.
  task automatic tick(input logic a_rst, input logic a_ack);
    logic [NC-1:0] e_cols;
    bit            acc;
    bit            hit_any;
    bit            held_seen;
    logic [5:0]    hit_code;
    int            hc;
    if (checking) begin
      e_cols = NC'(1) << ((n / SD) % NC);
      tests++;
      if (cols !== e_cols || code !== e_code || valid !== e_valid ||
          down !== e_down || ovr !== e_ovr) begin
        fails++;
        $display("FAIL cycle n=%0d: got cols=%b code=%b valid=%b down=%b ovr=%b want cols=%b code=%b valid=%b down=%b ovr=%b",
                 n, cols, code, valid, down, ovr, e_cols, e_code, e_valid, e_down, e_ovr);
      end
    end
    rst = a_rst;
    ack = a_ack;
    if (n % FRAME == 0) mat = plan;
    if (a_rst) begin
      n = 0; m_state = 0; m_cnt = 0; m_rel = 0; m_cand = 6'd0;
      e_code = 6'd0; e_valid = 1'b0; e_down = 1'b0; e_ovr = 1'b0;
    end else begin
      acc   = 1'b0;
      e_ovr = 1'b0;
      if (n > 0 && n % FRAME == 0) begin
        hit_any  = 1'b0;
        hit_code = 6'd0;
        for (int c = 0; c < NC; c++) begin
          for (int r = 0; r < NR; r++) begin
            if (snap[c][r] && !hit_any) begin
              hit_any  = 1'b1;
              hit_code = {3'(c), 3'(r)};
            end
          end
        end
        hc        = int'(e_code[5:3]);
        held_seen = (hc < NC) ? snap[hc][e_code[2:0]] : 1'b0;
        case (m_state)
          0: if (hit_any) begin
               m_cand = hit_code;
               m_cnt  = 1;
               if (DB == 1) acc = 1'b1;
               else         m_state = 1;
             end
          1: if (hit_any && hit_code == m_cand) begin
               m_cnt++;
               if (m_cnt == DB) acc = 1'b1;
             end else begin
               m_state = 0;
               m_cnt   = 0;
             end
          default: if (held_seen) m_rel = 0;
                   else begin
                     m_rel++;
                     if (m_rel == DB) begin
                       e_down  = 1'b0;
                       m_state = 0;
                     end
                   end
        endcase
      end
      if (acc) begin
        e_ovr   = e_valid && !a_ack;
        e_valid = 1'b1;
        e_code  = m_cand;
        e_down  = 1'b1;
        m_state = 2;
        m_rel   = 0;
        $display("[TB] accept n=%0d code=%b overrun=%0b", n, m_cand, e_ovr);
      end else if (e_valid && a_ack) begin
        e_valid = 1'b0;
      end
      if (n % FRAME == 0) snap = mat;
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_until(input int target);
    while (n < target) tick(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; ack = 1'b0;
    mat = '0; plan = '0; snap = '0;
    n = 0; tests = 0; fails = 0; checking = 1'b0;
    m_state = 0; m_cnt = 0; m_rel = 0; m_cand = 6'd0;
    e_code = 6'd0; e_valid = 1'b0; e_down = 1'b0; e_ovr = 1'b0;
    do_reset();
    checking = 1'b1;

    // Idle scan: column walk and quiet outputs
    lit("rst_cols", 8'(cols), 8'h01);
    lit("rst_code", 8'(code), 8'h00);
    lit("rst_flags", {5'd0, valid, down, ovr}, 8'h00);
    run_until(4);  lit("cols_c1", 8'(cols), 8'h02);
    run_until(19); lit("cols_c4", 8'(cols), 8'h10);
    run_until(20); lit("cols_wrap", 8'(cols), 8'h01);
    run_until(60); lit("idle_valid", 8'(valid), 8'h00);

    // Single press, ack, release
    do_reset();
    plan = '0; plan[2][5] = 1'b1;
    run_until(40); lit("press_valid_early", 8'(valid), 8'h00);
    tick(1'b0, 1'b0);
    lit("press_valid", 8'(valid), 8'h01);
    lit("press_code", 8'(code), 8'h15);
    lit("press_down", 8'(down), 8'h01);
    tick(1'b0, 1'b1);
    lit("ack_valid", 8'(valid), 8'h00);
    lit("ack_down", 8'(down), 8'h01);
    run_until(80); plan = '0;
    run_until(120); lit("release_down_hold", 8'(down), 8'h01);
    tick(1'b0, 1'b0);
    lit("release_down", 8'(down), 8'h00);

    // Bounce shorter than the debounce window
    do_reset();
    plan = '0; plan[1][0] = 1'b1;
    run_until(20); plan = '0;
    run_until(60); lit("bounce_valid", 8'(valid), 8'h00);

    // Two keys together: lowest column wins
    do_reset();
    plan = '0; plan[3][1] = 1'b1; plan[1][6] = 1'b1;
    run_until(41); lit("prio_code", 8'(code), 8'h0E);
    lit("prio_valid", 8'(valid), 8'h01);

    // Overrun: second key accepted without ack
    do_reset();
    plan = '0; plan[0][2] = 1'b1;
    run_until(40); plan = '0;
    run_until(80); plan = '0; plan[4][7] = 1'b1;
    run_until(121);
    lit("ovr_pulse", 8'(ovr), 8'h01);
    lit("ovr_code", 8'(code), 8'h27);
    lit("ovr_valid", 8'(valid), 8'h01);
    tick(1'b0, 1'b0);
    lit("ovr_clear", 8'(ovr), 8'h00);

    // Same, but ack lands with the second accept
    do_reset();
    plan = '0; plan[0][2] = 1'b1;
    run_until(40); plan = '0;
    run_until(80); plan = '0; plan[4][7] = 1'b1;
    run_until(120);
    tick(1'b0, 1'b1);
    lit("ackwin_ovr", 8'(ovr), 8'h00);
    lit("ackwin_valid", 8'(valid), 8'h01);
    lit("ackwin_code", 8'(code), 8'h27);

    // Reset mid-debounce and while a key is pending
    do_reset();
    plan = '0; plan[2][5] = 1'b1;
    run_until(25);
    tick(1'b1, 1'b0);
    lit("mid_rst_cols", 8'(cols), 8'h01);
    lit("mid_rst_flags", {5'd0, valid, down, ovr}, 8'h00);
    run_until(40); lit("redeb_early", 8'(valid), 8'h00);
    tick(1'b0, 1'b0);
    lit("redeb_valid", 8'(valid), 8'h01);
    tick(1'b1, 1'b0);
    lit("pend_rst_valid", 8'(valid), 8'h00);
    lit("pend_rst_code", 8'(code), 8'h00);

    // Randomised traffic
    do_reset();
    plan = '0;
    for (int k = 0; k < 3000; k++) begin
      if (n % FRAME == 0) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 4) begin
          // keep current keys
        end else if (r < 6) begin
          plan = '0;
        end else begin
          plan = '0;
          plan[$urandom_range(0, NC-1)][$urandom_range(0, NR-1)] = 1'b1;
          if (r == 9) plan[$urandom_range(0, NC-1)][$urandom_range(0, NR-1)] = 1'b1;
        end
      end
      tick($urandom_range(0, 999) == 0, $urandom_range(0, 5) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
